// File: rtl/riscv_lsu_pkg.sv
// rtl/riscv_lsu_pkg.sv - shared types, funct3 codes and lane helpers for riscv_lsu
package riscv_lsu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Pick the addressed byte/half out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  addr_lo,
                                                 input logic [2:0]  funct3);
        logic [31:0] shifted;
        logic [15:0] half;
        shifted = word >> {addr_lo, 3'b000};
        half    = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    lane_extract = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   lane_extract = {24'h0, shifted[7:0]};
            F3_H:    lane_extract = {{16{half[15]}}, half};
            F3_HU:   lane_extract = {16'h0, half};
            F3_W:    lane_extract = word;
            default: lane_extract = 32'h0;
        endcase
    endfunction

    // Overlay the low byte/half of the store data onto the addressed lane of the old word.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] data,
                                               input logic [1:0]  addr_lo,
                                               input logic [2:0]  funct3);
        logic [4:0] sh;
        sh = {addr_lo, 3'b000};
        case (funct3)
            F3_B:    lane_merge = (old_word & ~(32'h0000_00FF << sh)) | ({24'h0, data[7:0]} << sh);
            F3_H:    lane_merge = addr_lo[1] ? {data[15:0], old_word[15:0]}
                                             : {old_word[31:16], data[15:0]};
            default: lane_merge = data;
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// rtl/riscv_lsu_align.sv - lane extract/merge and access legality check (LSU_WSTRB_EN adds strobes)
module riscv_lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic        chk_rd,
    input  logic        chk_wr,
    input  logic [2:0]  chk_funct3,
    input  logic [1:0]  chk_addr_lo,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rd_word,
    input  logic [31:0] wr_data,
`ifdef LSU_WSTRB_EN
    input  logic [31:0] chk_data,
    output logic [3:0]  wstrb,
    output logic [31:0] wr_repl,
`endif
    output logic        chk_err,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic ld_ok;
    logic st_ok;
    logic misalign;

    // Reject conflicting requests, unsupported sizes and unaligned half/word accesses.
    always_comb begin
        ld_ok    = (chk_funct3 == F3_B) || (chk_funct3 == F3_H) || (chk_funct3 == F3_W) ||
                   (chk_funct3 == F3_BU) || (chk_funct3 == F3_HU);
        st_ok    = (chk_funct3 == F3_B) || (chk_funct3 == F3_H) || (chk_funct3 == F3_W);
        misalign = ((chk_funct3[1:0] == 2'b01) && chk_addr_lo[0]) ||
                   ((chk_funct3[1:0] == 2'b10) && (chk_addr_lo != 2'b00));
        chk_err  = (chk_rd && chk_wr) || (chk_rd && !ld_ok) || (chk_wr && !st_ok) || misalign;
    end

    assign ld_data = lane_extract(rd_word, addr_lo, funct3);
    assign st_word = lane_merge(rd_word, wr_data, addr_lo, funct3);

`ifdef LSU_WSTRB_EN
    // Replicate store data over every lane and enable only the addressed ones.
    always_comb begin
        case (chk_funct3)
            F3_B:    begin wstrb = 4'b0001 << chk_addr_lo;                wr_repl = {4{chk_data[7:0]}};  end
            F3_H:    begin wstrb = chk_addr_lo[1] ? 4'b1100 : 4'b0011;    wr_repl = {2{chk_data[15:0]}}; end
            default: begin wstrb = 4'b1111;                               wr_repl = chk_data;            end
        endcase
    end
`endif

endmodule

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - load/store unit FSM; define LSU_WSTRB_EN for byte-strobe stores
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [2:0]        funct3,
    input  logic [31:0]       m_addr,
    input  logic [31:0]       m_wr_dat,
    output logic [31:0]       m_rd_dat,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wr_dat,
`ifdef LSU_WSTRB_EN
    output logic [3:0]        mem_wstrb,
`endif
    input  logic [31:0]       mem_rd_dat
);

    lsu_state_e  state;
    logic [2:0]  f3_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] wdat_q;
    logic        store_q;
    logic        chk_err;
    logic [31:0] ld_data;
    logic [31:0] st_word;
`ifdef LSU_WSTRB_EN
    logic [3:0]  wstrb;
    logic [31:0] wr_repl;
`endif

    // Byte-address bits above the memory window are deliberately ignored.
    wire unused_addr_hi = ^m_addr[31:ADDR_W+2];

    riscv_lsu_align u_align (
        .chk_rd      (rd_en),
        .chk_wr      (wr_en),
        .chk_funct3  (funct3),
        .chk_addr_lo (m_addr[1:0]),
        .funct3      (f3_q),
        .addr_lo     (addr_lo_q),
        .rd_word     (mem_rd_dat),
        .wr_data     (wdat_q),
`ifdef LSU_WSTRB_EN
        .chk_data    (m_wr_dat),
        .wstrb       (wstrb),
        .wr_repl     (wr_repl),
`endif
        .chk_err     (chk_err),
        .ld_data     (ld_data),
        .st_word     (st_word)
    );

    // Request sequencing with every core/memory output registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            f3_q       <= 3'b000;
            addr_lo_q  <= 2'b00;
            wdat_q     <= 32'h0;
            store_q    <= 1'b0;
            m_rd_dat   <= 32'h0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            mem_addr   <= '0;
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_wr_dat <= 32'h0;
`ifdef LSU_WSTRB_EN
            mem_wstrb  <= 4'b0000;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (rd_en || wr_en) begin
                        f3_q      <= funct3;
                        addr_lo_q <= m_addr[1:0];
                        wdat_q    <= m_wr_dat;
                        store_q   <= wr_en;
                        mem_addr  <= m_addr[ADDR_W+1:2];
                        busy      <= 1'b1;
                        if (chk_err) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            err      <= 1'b1;
                            m_rd_dat <= 32'h0;
                        end else if (rd_en) begin
                            state     <= RD;
                            mem_rd_en <= 1'b1;
`ifdef LSU_WSTRB_EN
                        end else begin
                            state      <= WR;
                            mem_wr_en  <= 1'b1;
                            mem_wr_dat <= wr_repl;
                            mem_wstrb  <= wstrb;
                        end
`else
                        end else if (funct3 == F3_W) begin
                            state      <= WR;
                            mem_wr_en  <= 1'b1;
                            mem_wr_dat <= m_wr_dat;
                        end else begin
                            state     <= RD;
                            mem_rd_en <= 1'b1;
                        end
`endif
                    end
                end
                RD: begin
                    mem_rd_en <= 1'b0;
                    state     <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (store_q) begin
                        mem_wr_dat <= st_word;
                        mem_wr_en  <= 1'b1;
                        state      <= WR;
                    end else begin
                        m_rd_dat <= ld_data;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                WR: begin
                    mem_wr_en <= 1'b0;
`ifdef LSU_WSTRB_EN
                    mem_wstrb <= 4'b0000;
`endif
                    m_rd_dat  <= 32'h0;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - directed self-checking bench for riscv_lsu
module tb_riscv_lsu;
    import riscv_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  funct3;
    logic [31:0] m_addr;
    logic [31:0] m_wr_dat;
    logic [31:0] m_rd_dat;
    logic        busy;
    logic        done;
    logic        err;
    logic [9:0]  mem_addr;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_wr_dat;
    logic [31:0] mem_rd_dat;
`ifdef LSU_WSTRB_EN
    logic [3:0]  mem_wstrb;
    localparam int          SUB_CYC = 2;
    localparam int          SUB_RDS = 0;
    localparam logic [31:0] SB_WDAT = 32'hAAAA_AAAA;
    localparam logic [31:0] SH_WDAT = 32'hBEEF_BEEF;
`else
    localparam int          SUB_CYC = 4;
    localparam int          SUB_RDS = 1;
    localparam logic [31:0] SB_WDAT = 32'h1122_AA44;
    localparam logic [31:0] SH_WDAT = 32'hBEEF_AA44;
`endif

    logic [31:0] mem [0:1023];
    logic [3:0]  last_wstrb;

    int vectors     = 0;
    int miscompares = 0;

    riscv_lsu #(.ADDR_W(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .funct3     (funct3),
        .m_addr     (m_addr),
        .m_wr_dat   (m_wr_dat),
        .m_rd_dat   (m_rd_dat),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_dat (mem_wr_dat),
`ifdef LSU_WSTRB_EN
        .mem_wstrb  (mem_wstrb),
`endif
        .mem_rd_dat (mem_rd_dat)
    );

    always #5 clk = ~clk;

    // Word memory with one-cycle registered read.
    always @(posedge clk) begin
        if (mem_wr_en) begin
`ifdef LSU_WSTRB_EN
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_addr][b*8 +: 8] <= mem_wr_dat[b*8 +: 8];
`else
            mem[mem_addr] <= mem_wr_dat;
`endif
        end
        if (mem_rd_en) mem_rd_dat <= mem[mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_m_rd_dat"}, m_rd_dat, 32'h0);
        check({tag, "_ctrl"}, {28'h0, busy, done, err, mem_rd_en}, 32'h0);
        check({tag, "_mem_wr_en"}, {31'h0, mem_wr_en}, 32'h0);
        check({tag, "_mem_addr"}, {22'h0, mem_addr}, 32'h0);
        check({tag, "_mem_wr_dat"}, mem_wr_dat, 32'h0);
    endtask

    // Issue one request in IDLE and measure the completion relative to the accept edge.
    task automatic run_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data, input int exp_cyc,
                          input logic exp_err, input logic [31:0] exp_rd, input int exp_rds,
                          input int exp_wrs, input logic [31:0] exp_wdat);
        int got = 0;
        int rds = 0;
        int wrs = 0;
        int wcyc = 0;
        logic [31:0] wdat = 32'h0;
        logic [9:0]  waddr = 10'h0;
        @(negedge clk);
        rd_en = rd; wr_en = wr; funct3 = f3; m_addr = addr; m_wr_dat = data;
        @(posedge clk);
        #1;
        rd_en = 1'b0; wr_en = 1'b0;
        for (int k = 1; k <= 8 && got == 0; k++) begin
            @(negedge clk);
            if (mem_rd_en) rds++;
            if (mem_wr_en) begin
                wrs++; wcyc = k; wdat = mem_wr_dat; waddr = mem_addr;
`ifdef LSU_WSTRB_EN
                last_wstrb = mem_wstrb;
`endif
            end
            if (done) begin
                got = k;
                check({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
                check({tag, "_m_rd_dat"}, m_rd_dat, exp_rd);
                check({tag, "_busy"}, {31'h0, busy}, 32'h1);
            end
        end
        check({tag, "_done_cycle"}, got, exp_cyc);
        check({tag, "_rd_strobes"}, rds, exp_rds);
        check({tag, "_wr_strobes"}, wrs, exp_wrs);
        if (exp_wrs > 0) begin
            check({tag, "_wr_cycle"}, wcyc, exp_cyc - 1);
            check({tag, "_wr_dat"}, wdat, exp_wdat);
            check({tag, "_wr_addr"}, {22'h0, waddr}, {22'h0, addr[11:2]});
        end
        @(negedge clk);
        check({tag, "_idle"}, {30'h0, busy, done}, 32'h0);
    endtask

    initial begin
        reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0; funct3 = 3'b000;
        m_addr = 32'h0; m_wr_dat = 32'h0; last_wstrb = 4'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_zero("reset");

        // Word store / load
        run_op("sw_10", 0, 1, F3_W, 32'h10, 32'hDEAD_BEEF, 2, 0, 32'h0, 0, 1, 32'hDEAD_BEEF);
        check("sw_10_mem", mem[4], 32'hDEAD_BEEF);
        run_op("lw_10", 1, 0, F3_W, 32'h10, 32'h0, 3, 0, 32'hDEAD_BEEF, 1, 0, 32'h0);

        // Sub-word loads
        run_op("sw_20", 0, 1, F3_W, 32'h20, 32'h8081_F0F7, 2, 0, 32'h0, 0, 1, 32'h8081_F0F7);
        run_op("lb_21",  1, 0, F3_B,  32'h21, 32'h0, 3, 0, 32'hFFFF_FFF0, 1, 0, 32'h0);
        run_op("lbu_23", 1, 0, F3_BU, 32'h23, 32'h0, 3, 0, 32'h0000_0080, 1, 0, 32'h0);
        run_op("lh_22",  1, 0, F3_H,  32'h22, 32'h0, 3, 0, 32'hFFFF_8081, 1, 0, 32'h0);
        run_op("lhu_20", 1, 0, F3_HU, 32'h20, 32'h0, 3, 0, 32'h0000_F0F7, 1, 0, 32'h0);

        // Sub-word stores
        run_op("sw_30", 0, 1, F3_W, 32'h30, 32'h1122_3344, 2, 0, 32'h0, 0, 1, 32'h1122_3344);
        run_op("sb_31", 0, 1, F3_B, 32'h31, 32'h0000_00AA, SUB_CYC, 0, 32'h0, SUB_RDS, 1, SB_WDAT);
        check("sb_31_mem", mem[12], 32'h1122_AA44);
`ifdef LSU_WSTRB_EN
        check("sb_31_wstrb", {28'h0, last_wstrb}, 32'h2);
`endif
        run_op("sh_32", 0, 1, F3_H, 32'h32, 32'h0000_BEEF, SUB_CYC, 0, 32'h0, SUB_RDS, 1, SH_WDAT);
        check("sh_32_mem", mem[12], 32'hBEEF_AA44);
        run_op("lw_30", 1, 0, F3_W, 32'h30, 32'h0, 3, 0, 32'hBEEF_AA44, 1, 0, 32'h0);

        // Rejected accesses
        run_op("err_lw_12",  1, 0, F3_W,   32'h12, 32'h0, 1, 1, 32'h0, 0, 0, 32'h0);
        run_op("err_sh_33",  0, 1, F3_H,   32'h33, 32'h1234, 1, 1, 32'h0, 0, 0, 32'h0);
        run_op("err_f3_011", 1, 0, 3'b011, 32'h10, 32'h0, 1, 1, 32'h0, 0, 0, 32'h0);
        run_op("err_rd_wr",  1, 1, F3_W,   32'h10, 32'h5555_5555, 1, 1, 32'h0, 0, 0, 32'h0);
        check("err_mem_unchanged", mem[4], 32'hDEAD_BEEF);

`ifndef LSU_WSTRB_EN
        // Reset while the read-modify-write sits in RD_WAIT
        run_op("lw_30b", 1, 0, F3_W, 32'h30, 32'h0, 3, 0, 32'hBEEF_AA44, 1, 0, 32'h0);
        begin
            int wrs = 0;
            int dns = 0;
            @(negedge clk);
            wr_en = 1'b1; funct3 = F3_B; m_addr = 32'h31; m_wr_dat = 32'h55;
            @(posedge clk);
            #1 wr_en = 1'b0;
            @(negedge clk);
            check("rst_rd_strobe", {31'h0, mem_rd_en}, 32'h1);
            @(negedge clk);
            reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
            @(negedge clk);
            check_zero("rst_mid");
            for (int k = 0; k < 4; k++) begin
                if (mem_wr_en) wrs++;
                if (done) dns++;
                @(negedge clk);
            end
            check("rst_no_wr", wrs, 0);
            check("rst_no_done", dns, 0);
            check("rst_mem_kept", mem[12], 32'hBEEF_AA44);
        end
        run_op("lw_after_rst", 1, 0, F3_W, 32'h30, 32'h0, 3, 0, 32'hBEEF_AA44, 1, 0, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
